// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, 8 data bits LSB-first, parity, stop.
// Optional error injection input force_err is enabled by PARITY_TX_FORCE_ERR_EN.
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef PARITY_TX_FORCE_ERR_EN
  input  logic       force_err,
`endif
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic calc_parity(input logic [7:0] d, input logic odd, input logic inv);
    return (^d) ^ odd ^ inv;
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             force_err_s;
  logic             term_s;

`ifdef PARITY_TX_FORCE_ERR_EN
  assign force_err_s = force_err;
`else
  assign force_err_s = 1'b0;
`endif

  assign term_s     = (div_q == DIV_MAX);
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: divider, bit index, accept latching
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    if (state_q == S_IDLE || term_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        bit_d = 3'd0;
        if (data_valid) begin
          state_d = S_START;
          data_d  = data_in;
          par_d   = calc_parity(data_in, ODD_PARITY, force_err_s);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (term_s) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (term_s && bit_q == 3'd7) begin
          state_d = S_PARITY;
        end else if (term_s) begin
          bit_d = bit_q + 3'd1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (term_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (term_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output levels computed one cycle ahead from the next state
  always_comb begin
    data_ready = (state_q == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_STOP) && (div_d == DIV_MAX);
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_d];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three instances (CPB=4 even, CPB=1 even, CPB=2 odd)
// checked every cycle against a frame-position model plus directed literal checks.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst_a  [3];
  logic       vld_a  [3];
  logic       ferr_a [3];
  logic [7:0] din_a  [3];
  logic       rdy_a  [3];
  logic       tx_a   [3];
  logic       busy_a [3];
  logic       done_a [3];

  int cpb_a [3] = '{4, 1, 2};
  int odd_a [3] = '{0, 0, 1};

  int         mdl_pos  [3] = '{-1, -1, -1};
  logic [7:0] mdl_byte [3];
  logic       mdl_par  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) u4 (
    .clk(clk), .reset(rst_a[0]),
`ifdef PARITY_TX_FORCE_ERR_EN
    .force_err(ferr_a[0]),
`endif
    .data_in(din_a[0]), .data_valid(vld_a[0]), .data_ready(rdy_a[0]),
    .tx_out(tx_a[0]), .busy(busy_a[0]), .frame_done(done_a[0]));

  parity_frame_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b0)) u1 (
    .clk(clk), .reset(rst_a[1]),
`ifdef PARITY_TX_FORCE_ERR_EN
    .force_err(ferr_a[1]),
`endif
    .data_in(din_a[1]), .data_valid(vld_a[1]), .data_ready(rdy_a[1]),
    .tx_out(tx_a[1]), .busy(busy_a[1]), .frame_done(done_a[1]));

  parity_frame_tx #(.CLKS_PER_BIT(2), .ODD_PARITY(1'b1)) uo (
    .clk(clk), .reset(rst_a[2]),
`ifdef PARITY_TX_FORCE_ERR_EN
    .force_err(ferr_a[2]),
`endif
    .data_in(din_a[2]), .data_valid(vld_a[2]), .data_ready(rdy_a[2]),
    .tx_out(tx_a[2]), .busy(busy_a[2]), .frame_done(done_a[2]));

  // Model: position within the frame, -1 when idle
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_a[i]) begin
        mdl_pos[i] <= -1;
      end else if (mdl_pos[i] < 0) begin
        if (vld_a[i]) begin
          mdl_pos[i]  <= 0;
          mdl_byte[i] <= din_a[i];
          mdl_par[i]  <= (^din_a[i]) ^ odd_a[i][0] ^ ferr_a[i];
        end
      end else if (mdl_pos[i] == 11 * cpb_a[i] - 1) begin
        mdl_pos[i] <= -1;
      end else begin
        mdl_pos[i] <= mdl_pos[i] + 1;
      end
    end
  end

  // Expected {tx_out, data_ready, busy, frame_done}
  function automatic logic [3:0] mdl_out(input int pos, input int cpb, input logic [7:0] b, input logic p);
    int k;
    logic t;
    if (pos < 0) return 4'b1100;
    k = pos / cpb;
    if (k == 0) t = 1'b0;
    else if (k <= 8) t = b[k-1];
    else if (k == 9) t = p;
    else t = 1'b1;
    return {t, 1'b0, 1'b1, (pos == 11 * cpb - 1)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_cap(input int i, input logic [7:0] b, input logic fe, input bit scramble,
                          output logic [10:0] bits, output int done_cyc);
    bit ok;
    @(negedge clk);
    vld_a[i] = 1'b1; din_a[i] = b; ferr_a[i] = fe;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rdy_a[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    bits = '1;
    done_cyc = -1;
    for (int c = 0; c < 11 * cpb_a[i]; c++) begin
      @(negedge clk);
      vld_a[i] = 1'b0; ferr_a[i] = 1'b0;
      if (scramble) din_a[i] = 8'($urandom);
      if (c % cpb_a[i] == cpb_a[i] / 2) bits[c / cpb_a[i]] = tx_a[i];
      if (done_a[i] && done_cyc < 0) done_cyc = c + 1;
    end
  endtask

  logic [10:0] bits, bits2;
  int          dc, rdy_cnt, rdy_at;
  logic        tx_gap, tx_next;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; vld_a[i] = 1'b0; ferr_a[i] = 1'b0; din_a[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    chk("reset_u4", {28'd0, tx_a[0], rdy_a[0], busy_a[0], done_a[0]}, 32'hC);
    chk("reset_u1", {28'd0, tx_a[1], rdy_a[1], busy_a[1], done_a[1]}, 32'hC);
    chk("reset_uo", {28'd0, tx_a[2], rdy_a[2], busy_a[2], done_a[2]}, 32'hC);

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++)
          chk($sformatf("cycle_u%0d", i), {28'd0, tx_a[i], rdy_a[i], busy_a[i], done_a[i]},
              {28'd0, mdl_out(mdl_pos[i], cpb_a[i], mdl_byte[i], mdl_par[i])});
      end
    join_none

    send_cap(0, 8'hA5, 1'b0, 1'b0, bits, dc);
    chk("a5_bits", {21'd0, bits}, {21'd0, 11'b10_1010_0101_0});
    chk("a5_done_cycle", 32'(dc), 32'd44);

    send_cap(1, 8'h01, 1'b0, 1'b0, bits, dc);
    chk("even_01_bits", {21'd0, bits}, {21'd0, 11'b11_0000_0001_0});
    send_cap(2, 8'h00, 1'b0, 1'b0, bits, dc);
    chk("odd_00_bits", {21'd0, bits}, {21'd0, 11'b11_0000_0000_0});
    send_cap(2, 8'hFF, 1'b0, 1'b0, bits, dc);
    chk("odd_ff_bits", {21'd0, bits}, {21'd0, 11'b11_1111_1111_0});

    // Back-to-back frames with data_valid held high, one bit per clock
    @(negedge clk);
    vld_a[1] = 1'b1; din_a[1] = 8'h3C;
    @(posedge clk);
    rdy_cnt = 0; rdy_at = -1; tx_gap = 1'b0; tx_next = 1'b1;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      din_a[1] = 8'hC3;
      if (rdy_a[1]) begin
        rdy_cnt++;
        rdy_at = c;
      end
      if (c < 11) bits[c] = tx_a[1];
      if (c == 11) tx_gap = tx_a[1];
      if (c == 12) tx_next = tx_a[1];
      if (c >= 12) bits2[c-12] = tx_a[1];
      if (c == 22) vld_a[1] = 1'b0;
    end
    chk("b2b_frame1", {21'd0, bits}, {21'd0, 11'b10_0011_1100_0});
    chk("b2b_frame2", {21'd0, bits2}, {21'd0, 11'b10_1100_0011_0});
    chk("b2b_ready_count", 32'(rdy_cnt), 32'd1);
    chk("b2b_ready_at_gap", 32'(rdy_at), 32'd11);
    chk("b2b_gap_tx", {31'd0, tx_gap}, 32'd1);
    chk("b2b_start_after_gap", {31'd0, tx_next}, 32'd0);

    // Reset during data bit 3
    @(negedge clk);
    vld_a[0] = 1'b1; din_a[0] = 8'hF0;
    @(posedge clk);
    repeat (17) begin
      @(negedge clk);
      vld_a[0] = 1'b0;
    end
    rst_a[0] = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {28'd0, tx_a[0], rdy_a[0], busy_a[0], done_a[0]}, 32'hC);
    rst_a[0] = 1'b0;
    send_cap(0, 8'h55, 1'b0, 1'b0, bits, dc);
    chk("after_reset_55", {21'd0, bits}, {21'd0, 11'b10_0101_0101_0});

    send_cap(0, 8'h81, 1'b0, 1'b1, bits, dc);
    chk("scramble_81", {21'd0, bits}, {21'd0, 11'b10_1000_0001_0});

`ifdef PARITY_TX_FORCE_ERR_EN
    send_cap(0, 8'hA5, 1'b1, 1'b0, bits, dc);
    chk("force_err_on", {21'd0, bits}, {21'd0, 11'b11_1010_0101_0});
    send_cap(0, 8'hA5, 1'b0, 1'b0, bits, dc);
    chk("force_err_off", {21'd0, bits}, {21'd0, 11'b10_1010_0101_0});
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
